// File: rtl/aes_pkg.sv
// AES key-schedule constants, state encoding and byte helpers (S-box, xtime, inv_xtime).
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable.
package aes_pkg;

    localparam int         AES_NR      = 10;
    localparam logic [7:0] RCON_LAST   = 8'h36;
    localparam logic [7:0] INV_RC_POLY = 8'h8D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Divide by x in GF(2^8): exact inverse of xtime.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ((x >> 1) ^ INV_RC_POLY) : (x >> 1);
    endfunction

endpackage

// File: rtl/aes_key_gword.sv
// Key-schedule G function: RotWord, SubWord over 4 S-boxes, then rc into byte 0.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module aes_key_gword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  rc_i,
    output logic [31:0] word_o
);

    logic [31:0] rot;

    assign rot = {word_i[23:0], word_i[31:24]};

    assign word_o = {sbox(rot[31:24]) ^ rc_i,
                     sbox(rot[23:16]),
                     sbox(rot[15:8]),
                     sbox(rot[7:0])};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 round keys emitted NR..0 from one 128-bit register; optional AES_INV_LAST_KEY_LOAD_EN adds a direct last-key load.
// Latency: NR cycles of forward expansion after start, then one key per cycle (start to done 2*NR+3 cycles inclusive).
// Backpressure: rk_valid/rk_ready; rk_data/rk_idx/rk_valid hold while stalled.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int         NR      = AES_NR,
    parameter logic [7:0] RC_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
`ifdef AES_INV_LAST_KEY_LOAD_EN
    input  logic         ld_last,
    input  logic [127:0] last_key,
`endif
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         done
);

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] LAST_FWD = 4'(NR - 1);

    state_e       state_q;
    logic [127:0] kreg_q;
    logic [7:0]   rc_q;
    logic [3:0]   cnt_q;
    logic         busy_q;
    logic         rk_valid_q;
    logic         done_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p3;
    logic [31:0]  g_in;
    logic [31:0]  g_out;
    logic [31:0]  o0, o1, o2, o3;
    logic [127:0] fwd_d;
    logic [127:0] inv_d;

    assign w0 = kreg_q[127:96];
    assign w1 = kreg_q[95:64];
    assign w2 = kreg_q[63:32];
    assign w3 = kreg_q[31:0];

    // p3 is the previous round's w3; the single G instance serves both directions.
    assign p3   = w3 ^ w2;
    assign g_in = (state_q == EMIT) ? p3 : w3;

    aes_key_gword u_gword (
        .word_i (g_in),
        .rc_i   (rc_q),
        .word_o (g_out)
    );

    // Forward expansion chain: each word depends on the one just produced.
    assign o0    = w0 ^ g_out;
    assign o1    = o0 ^ w1;
    assign o2    = o1 ^ w2;
    assign o3    = o2 ^ w3;
    assign fwd_d = {o0, o1, o2, o3};

    // Inverse expansion: undo the chain, then recover w0 through G of the recovered w3.
    assign inv_d = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    // Schedule FSM with counter, key register, round constant and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            kreg_q     <= '0;
            rc_q       <= RC_INIT;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef AES_INV_LAST_KEY_LOAD_EN
                    if (ld_last) begin
                        kreg_q     <= last_key;
                        rc_q       <= RCON_LAST;
                        cnt_q      <= NR_IDX;
                        state_q    <= EMIT;
                        busy_q     <= 1'b1;
                        rk_valid_q <= 1'b1;
                    end else
`endif
                    if (start) begin
                        kreg_q  <= key;
                        rc_q    <= RC_INIT;
                        cnt_q   <= '0;
                        state_q <= FWD;
                        busy_q  <= 1'b1;
                    end
                end
                FWD: begin
                    kreg_q <= fwd_d;
                    cnt_q  <= cnt_q + 4'd1;
                    // rc is left at the round-NR constant for the first inverse step.
                    if (cnt_q == LAST_FWD) begin
                        state_q    <= EMIT;
                        rk_valid_q <= 1'b1;
                    end else begin
                        rc_q <= xtime(rc_q);
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (cnt_q != 4'd0) begin
                            kreg_q <= inv_d;
                            rc_q   <= inv_xtime(rc_q);
                            cnt_q  <= cnt_q - 4'd1;
                        end else begin
                            state_q    <= DONE;
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    rk_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = kreg_q;
    assign rk_idx   = cnt_q;
    assign rk_last  = rk_valid_q && (cnt_q == 4'd0);
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: reference expansion built from GF(2^8) arithmetic.
// Each run emits all 11 round keys and compares them, their order and handshake timing.
// Also covers random stalls, ignored restart, mid-run reset and the optional last-key load.
module tb_aes_inv_key_schedule;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         done;
`ifdef AES_INV_LAST_KEY_LOAD_EN
    logic         ld_last;
    logic [127:0] last_key;
`endif

    int checks;
    int errors;

    logic [7:0]   sb[0:255];
    logic [127:0] exp_rk[0:10];
    logic [127:0] got[0:10];

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
`ifdef AES_INV_LAST_KEY_LOAD_EN
        .ld_last  (ld_last),
        .last_key (last_key),
`endif
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (b^254) then the affine map.
    task automatic build_sbox();
        logic [7:0]  inv;
        logic [15:0] d;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
            d = {inv, inv};
            sb[b] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
        end
    endtask

    // Textbook 44-word key expansion; round key r is words 4r..4r+3.
    task automatic model(input logic [127:0] k);
        logic [31:0] w[0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rcon, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // One full schedule; e counts clock edges after the edge that accepts start / ld_last.
    task automatic run_seq(input logic [127:0] k, input int stall_pct, input bit poke, input bit use_ld);
        int           idx;
        int           first_v;
        int           done_e;
        bit           stalled;
        bit           poked;
        logic [127:0] pdat;
        logic [3:0]   pidx;
        model(k);
        idx = NR; first_v = -1; done_e = -1; stalled = 0; poked = 0; pdat = '0; pidx = '0;
        for (int r = 0; r <= NR; r++) got[r] = '0;
        rk_ready = 1'b1;
        if (use_ld) begin
`ifdef AES_INV_LAST_KEY_LOAD_EN
            ld_last  = 1'b1;
            last_key = exp_rk[NR];
            start    = 1'b1;
            key      = '0;
`endif
        end else begin
            start = 1'b1;
            key   = k;
        end
        @(posedge clk); #1;
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_LAST_KEY_LOAD_EN
        ld_last  = 1'b0;
        last_key = {$urandom, $urandom, $urandom, $urandom};
`endif
        for (int e = 0; e < 400 && done_e < 0; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (stalled) begin
                chk("stall_valid", rk_valid, 1'b1);
                chk("stall_data", rk_data, pdat);
                chk("stall_idx", rk_idx, pidx);
            end
            if (rk_valid) begin
                if (first_v < 0) first_v = e;
                chk("rk_idx", rk_idx, idx);
                chk("rk_data", rk_data, (idx >= 0 && idx <= NR) ? exp_rk[idx] : '0);
                chk("rk_last", rk_last, idx == 0);
            end else begin
                chk("rk_last_low", rk_last, 1'b0);
            end
            if (done) begin
                done_e = e;
                chk("keys_left_at_done", idx + 1, 0);
            end else begin
                chk("busy_high", busy, 1'b1);
            end
            rk_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            stalled  = rk_valid && !rk_ready;
            pdat     = rk_data;
            pidx     = rk_idx;
            if (rk_valid && rk_ready) begin
                if (idx >= 0 && idx <= NR) got[idx] = rk_data;
                idx--;
            end
            if (poke && !poked && rk_valid && rk_idx == 4'd7) begin
                start = 1'b1;
                key   = '0;
                poked = 1;
            end
        end
        chk("done_seen", done_e >= 0, 1'b1);
        if (stall_pct == 0) begin
            chk("first_valid_cycle", first_v, use_ld ? 0 : NR);
            chk("done_cycle", done_e, use_ld ? NR + 1 : 2 * NR + 1);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", rk_valid, 1'b0);
        rk_ready = 1'b0;
    endtask

    initial begin
        bit found;
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
`ifdef AES_INV_LAST_KEY_LOAD_EN
        ld_last = 1'b0; last_key = '0;
`endif
        build_sbox();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_data", rk_data, '0);
        chk("rst_idx", rk_idx, '0);
        chk("rst_last", rk_last, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_stays_idle", busy, 1'b0);

        // FIPS-197 key, consumer always ready: done lands in the 23rd cycle counting start as the first.
        run_seq(FIPS_KEY, 0, 0, 0);
        chk("fips_idx10", got[10], FIPS_RK10);
        chk("fips_idx1", got[1], FIPS_RK1);
        chk("fips_idx0", got[0], FIPS_KEY);

        // Same key under random backpressure.
        run_seq(FIPS_KEY, 50, 0, 0);
        chk("stall_fips_idx10", got[10], FIPS_RK10);
        chk("stall_fips_idx0", got[0], FIPS_KEY);

        // start with key=0 while emitting must be ignored.
        run_seq(FIPS_KEY, 0, 1, 0);
        chk("poke_idx0", got[0], FIPS_KEY);

        // Asynchronous reset while idx 5 is on the bus.
        rk_ready = 1'b1;
        start = 1'b1; key = FIPS_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int e = 0; e < 100 && !found; e++) begin
            if (rk_valid && rk_idx == 4'd5) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reach_idx5", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", rk_valid, 1'b0);
        chk("arst_data", rk_data, '0);
        chk("arst_idx", rk_idx, '0);
        chk("arst_last", rk_last, 1'b0);
        chk("arst_done", done, 1'b0);
        #1 rst = 1'b0;
        rk_ready = 1'b0;
        run_seq(FIPS_KEY, 0, 0, 0);
        chk("post_rst_idx10", got[10], FIPS_RK10);

        // All-zero key.
        run_seq('0, 0, 0, 0);
        chk("zero_idx10", got[10], ZERO_RK10);
        chk("zero_idx0", got[0], '0);

        // Random keys with random stalls.
        for (int n = 0; n < 3; n++) begin
            run_seq({$urandom, $urandom, $urandom, $urandom}, 30, 0, 0);
        end

`ifdef AES_INV_LAST_KEY_LOAD_EN
        // Direct last-key load, with a simultaneous start that must lose.
        run_seq(FIPS_KEY, 0, 0, 1);
        chk("ld_idx10", got[10], FIPS_RK10);
        chk("ld_idx0", got[0], FIPS_KEY);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 40, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
